// File: rtl/rotation_angle_tracker.sv
// rotation_angle_tracker
//   Measures the rotor period between accepted IR index edges and splits it
//   into ROTATIONAL_RES angular slices. A restoring divider yields
//   q = period / RES and r = period % RES. Slices last q or q+1 cycles, with
//   the remainder spread through an accumulator. The output angle is
//   phase-shifted and registered.
//
// Ports
//   clk_in           system clock
//   rst_n_in         asynchronous active-low reset
//   index_in         debounced IR index level (synchronous to clk_in)
//   phase_offset_in  angle offset; values >= ROTATIONAL_RES act as 0
//   theta_out        phase-adjusted angle (registered)
//   theta_valid_out  one-cycle strobe when theta_out takes a new slice value
//   period_out       last accepted revolution period in cycles
//   locked_out       slice timing valid
//   stall_out        rotor stopped; sticky until the next edge
module rotation_angle_tracker #(
    parameter int unsigned ROTATIONAL_RES = 1024,
    parameter int unsigned PERIOD_WIDTH   = 24,
    parameter int unsigned MIN_PERIOD     = 2048
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              index_in,
    input  logic [$clog2(ROTATIONAL_RES)-1:0] phase_offset_in,
    output logic [$clog2(ROTATIONAL_RES)-1:0] theta_out,
    output logic                              theta_valid_out,
    output logic [PERIOD_WIDTH-1:0]           period_out,
    output logic                              locked_out,
    output logic                              stall_out
);

    localparam int unsigned TW  = $clog2(ROTATIONAL_RES);
    localparam int unsigned PW  = PERIOD_WIDTH;
    localparam int unsigned DCW = $clog2(PW) + 1;

    localparam logic [PW-1:0]  CNT_MAX   = '1;
    localparam logic [PW-1:0]  MIN_P     = PW'(MIN_PERIOD);
    localparam logic [PW:0]    RES_D     = (PW+1)'(ROTATIONAL_RES);
    localparam logic [PW-1:0]  RES_P     = PW'(ROTATIONAL_RES);
    localparam logic [TW:0]    RES_T     = (TW+1)'(ROTATIONAL_RES);
    localparam logic [TW-1:0]  RES_TW    = TW'(ROTATIONAL_RES);
    localparam logic [TW-1:0]  THETA_MAX = TW'(ROTATIONAL_RES - 1);
    localparam logic [DCW-1:0] DIV_LAST  = DCW'(PW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_DIVIDE,
        S_RUN
    } state_t;

    state_t state_q, state_d;

    logic           index_q;
    logic [PW-1:0]  cnt_q;
    logic [PW-1:0]  div_dvd_q;
    logic [PW-1:0]  div_rem_q;
    logic [DCW-1:0] div_cnt_q;
    logic [PW-1:0]  q_cur, q_new;
    logic [TW-1:0]  r_cur, r_new;
    logic           new_pend;
    logic [TW-1:0]  acc_q;
    logic [PW-1:0]  slice_tmr_q;
    logic [TW-1:0]  theta_raw_q;
    logic           theta_evt_q;

    logic           rise;
    logic           first_edge, period_edge, edge_acc;
    logic           stall_evt, div_done;

    logic [PW:0]    div_trial;
    logic           div_ge;
    logic [PW-1:0]  div_diff, div_rem_nxt, div_quo_nxt;

    logic [TW:0]    acc_sum;
    logic           slice_long, slice_end;
    logic [TW-1:0]  acc_nxt;

    logic [TW-1:0]  off_eff;
    logic [TW:0]    theta_sum;
    logic [TW-1:0]  theta_adj;

    assign rise     = index_in & ~index_q;
    assign edge_acc = first_edge | period_edge;

    // Edges during DIVIDE are never accepted: the counter restarted on the
    // edge that entered DIVIDE and cannot reach MIN_PERIOD before it ends.
    always_comb begin
        state_d     = state_q;
        first_edge  = 1'b0;
        period_edge = 1'b0;
        stall_evt   = 1'b0;
        div_done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    first_edge = 1'b1;
                    state_d    = S_MEASURE;
                end
            end
            S_MEASURE, S_RUN: begin
                if (rise && (cnt_q >= MIN_P)) begin
                    period_edge = 1'b1;
                    state_d     = S_DIVIDE;
                end else if (cnt_q == CNT_MAX) begin
                    stall_evt = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_DIVIDE: begin
                if (cnt_q == CNT_MAX) begin
                    stall_evt = 1'b1;
                    state_d   = S_IDLE;
                end else if (div_cnt_q == DIV_LAST) begin
                    div_done = 1'b1;
                    state_d  = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Restoring divider: dividend bits shift out of div_dvd_q's MSB while
    // quotient bits shift into its LSB, so after PW steps it holds q.
    always_comb begin
        div_trial   = {div_rem_q, div_dvd_q[PW-1]};
        div_ge      = (div_trial >= RES_D);
        div_diff    = div_trial[PW-1:0] - RES_P;
        div_rem_nxt = div_ge ? div_diff : div_trial[PW-1:0];
        div_quo_nxt = {div_dvd_q[PW-2:0], div_ge};
    end

    always_comb begin
        acc_sum    = {1'b0, acc_q} + {1'b0, r_cur};
        slice_long = (acc_sum >= RES_T);
        acc_nxt    = slice_long ? (acc_sum[TW-1:0] - RES_TW) : acc_sum[TW-1:0];
        slice_end  = locked_out &&
                     (slice_long ? (slice_tmr_q == q_cur)
                                 : (slice_tmr_q == q_cur - PW'(1)));
    end

    always_comb begin
        off_eff   = ({1'b0, phase_offset_in} >= RES_T) ? '0 : phase_offset_in;
        theta_sum = {1'b0, theta_raw_q} + {1'b0, off_eff};
        theta_adj = (theta_sum >= RES_T) ? (theta_sum[TW-1:0] - RES_TW)
                                         : theta_sum[TW-1:0];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            index_q         <= 1'b0;
            cnt_q           <= '0;
            period_out      <= '0;
            div_dvd_q       <= '0;
            div_rem_q       <= '0;
            div_cnt_q       <= '0;
            q_cur           <= '0;
            r_cur           <= '0;
            q_new           <= '0;
            r_new           <= '0;
            new_pend        <= 1'b0;
            acc_q           <= '0;
            slice_tmr_q     <= '0;
            theta_raw_q     <= '0;
            theta_evt_q     <= 1'b0;
            theta_valid_out <= 1'b0;
            theta_out       <= '0;
            locked_out      <= 1'b0;
            stall_out       <= 1'b0;
        end else begin
            index_q <= index_in;

            // Counter starts at 1 after an edge so it reads the full
            // distance in cycles on the cycle the next edge is sampled.
            if (edge_acc)
                cnt_q <= PW'(1);
            else if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + PW'(1);

            if (period_edge)
                period_out <= cnt_q;

            if (period_edge) begin
                div_dvd_q <= cnt_q;
                div_rem_q <= '0;
                div_cnt_q <= '0;
            end else if (state_q == S_DIVIDE) begin
                div_dvd_q <= div_quo_nxt;
                div_rem_q <= div_rem_nxt;
                div_cnt_q <= div_cnt_q + DCW'(1);
            end

            if (stall_evt) begin
                stall_out   <= 1'b1;
                locked_out  <= 1'b0;
                theta_raw_q <= '0;
                slice_tmr_q <= '0;
                acc_q       <= '0;
                new_pend    <= 1'b0;
            end else if (edge_acc) begin
                theta_raw_q <= '0;
                slice_tmr_q <= '0;
                acc_q       <= '0;
                if (first_edge)
                    stall_out <= 1'b0;
            end else if (slice_end) begin
                slice_tmr_q <= '0;
                acc_q       <= acc_nxt;
                if (theta_raw_q != THETA_MAX)
                    theta_raw_q <= theta_raw_q + TW'(1);
                if (new_pend) begin
                    q_cur    <= q_new;
                    r_cur    <= r_new;
                    new_pend <= 1'b0;
                end
            end else if (locked_out) begin
                slice_tmr_q <= slice_tmr_q + PW'(1);
            end

            // Placed after the slice logic so a result finishing on a slice
            // boundary stays pending until the following boundary.
            if (div_done) begin
                if (!locked_out) begin
                    q_cur      <= div_quo_nxt;
                    r_cur      <= div_rem_nxt[TW-1:0];
                    locked_out <= 1'b1;
                end else begin
                    q_new    <= div_quo_nxt;
                    r_new    <= div_rem_nxt[TW-1:0];
                    new_pend <= 1'b1;
                end
            end

            theta_evt_q     <= locked_out && !stall_evt &&
                               (period_edge ||
                                (slice_end && (theta_raw_q != THETA_MAX)));
            theta_valid_out <= theta_evt_q;
            theta_out       <= theta_adj;
        end
    end

endmodule

// File: tb/tb_rotation_angle_tracker.sv
// Directed bench for rotation_angle_tracker using three instances:
//   u_a: RES=1024, W=24, MIN=2048 - exact division, glitch rejection, reset
//   u_b: RES=1000, W=24, MIN=2048 - remainder spreading, phase wrap
//   u_c: RES=100,  W=12, MIN=128  - stall and recovery
// Cycle notation: an edge sampled at cycle k; tasks return #1 after the
// posedge that ends a cycle, so after edge task the bench sits at k+1.
// theta_raw = n from k+1+S(n), with S(n) the sum of the first n slice
// lengths; theta_out follows one cycle later.
module tb_rotation_angle_tracker;

    logic clk;
    logic rst_n_a, rst_n;

    logic        idx_a, idx_b, idx_c;
    logic [9:0]  off_a, off_b;
    logic [6:0]  off_c;
    logic [9:0]  th_a, th_b;
    logic [6:0]  th_c;
    logic        vl_a, vl_b, vl_c;
    logic [23:0] per_a, per_b;
    logic [11:0] per_c;
    logic        lk_a, lk_b, lk_c;
    logic        st_a, st_b, st_c;

    int n_checks;
    int n_pass;

    rotation_angle_tracker #(.ROTATIONAL_RES(1024), .PERIOD_WIDTH(24), .MIN_PERIOD(2048)) u_a (
        .clk_in(clk), .rst_n_in(rst_n_a), .index_in(idx_a), .phase_offset_in(off_a),
        .theta_out(th_a), .theta_valid_out(vl_a), .period_out(per_a),
        .locked_out(lk_a), .stall_out(st_a));

    rotation_angle_tracker #(.ROTATIONAL_RES(1000), .PERIOD_WIDTH(24), .MIN_PERIOD(2048)) u_b (
        .clk_in(clk), .rst_n_in(rst_n), .index_in(idx_b), .phase_offset_in(off_b),
        .theta_out(th_b), .theta_valid_out(vl_b), .period_out(per_b),
        .locked_out(lk_b), .stall_out(st_b));

    rotation_angle_tracker #(.ROTATIONAL_RES(100), .PERIOD_WIDTH(12), .MIN_PERIOD(128)) u_c (
        .clk_in(clk), .rst_n_in(rst_n), .index_in(idx_c), .phase_offset_in(off_c),
        .theta_out(th_c), .theta_valid_out(vl_c), .period_out(per_c),
        .locked_out(lk_c), .stall_out(st_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic edge_a;
        idx_a = 1'b1;
        tick(1);
        idx_a = 1'b0;
    endtask

    task automatic edge_b;
        idx_b = 1'b1;
        tick(1);
        idx_b = 1'b0;
    endtask

    task automatic edge_c;
        idx_c = 1'b1;
        tick(1);
        idx_c = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n_a  = 1'b1;
        rst_n    = 1'b1;
        idx_a = 1'b0; idx_b = 1'b0; idx_c = 1'b0;
        off_a = '0;   off_b = '0;   off_c = 7'd7;
        #2;
        rst_n_a = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("rst_theta", 32'(th_a), 0);
        chk("rst_valid", 32'(vl_a), 0);
        chk("rst_period", 32'(per_a), 0);
        chk("rst_locked", 32'(lk_a), 0);
        chk("rst_stall", 32'(st_a), 0);
        tick(3);
        rst_n_a = 1'b1;
        rst_n   = 1'b1;
        tick(2);

        // ---- u_a: exact division, P = 10240 = 1024*10 ----
        edge_a;                                   // k1+1
        chk("a_first_period", 32'(per_a), 0);
        chk("a_first_locked", 32'(lk_a), 0);
        tick(10239);
        edge_a;                                   // k2+1
        chk("a_period", 32'(per_a), 10240);
        chk("a_unlocked_k24", 32'(lk_a), 0);
        tick(23);                                 // k2+24
        chk("a_lock_k24", 32'(lk_a), 0);
        tick(1);                                  // k2+25
        chk("a_lock_k25", 32'(lk_a), 1);
        tick(10240 - 25);
        edge_a;                                   // k3+1
        tick(1);                                  // k3+2
        chk("a_edge_theta", 32'(th_a), 0);
        chk("a_edge_valid", 32'(vl_a), 1);
        tick(9);                                  // k3+11
        chk("a_s1_theta", 32'(th_a), 0);
        chk("a_s1_valid", 32'(vl_a), 0);
        tick(1);                                  // k3+12
        chk("a_s1_theta_inc", 32'(th_a), 1);
        chk("a_s1_valid_inc", 32'(vl_a), 1);
        tick(288);                                // k3+300: glitch
        idx_a = 1'b1;
        tick(1);                                  // k3+301
        idx_a = 1'b0;
        chk("a_glitch_period", 32'(per_a), 10240);
        chk("a_glitch_theta", 32'(th_a), 29);
        tick(1);                                  // k3+302
        chk("a_glitch_theta2", 32'(th_a), 30);
        tick(10231 - 302);                        // k3+10231
        chk("a_theta_1022", 32'(th_a), 1022);
        tick(1);                                  // k3+10232
        chk("a_theta_1023", 32'(th_a), 1023);
        chk("a_valid_1023", 32'(vl_a), 1);
        tick(8);                                  // k4: saturated, no wrap
        chk("a_sat_theta", 32'(th_a), 1023);
        chk("a_sat_valid", 32'(vl_a), 0);
        edge_a;                                   // k4+1
        chk("a_period_after_glitch", 32'(per_a), 10240);
        tick(1);                                  // k4+2
        chk("a_wrap_theta", 32'(th_a), 0);
        chk("a_wrap_valid", 32'(vl_a), 1);
        tick(100);                                // k4+102
        chk("a_pre_reset_theta", 32'(th_a), 10);

        // asynchronous reset mid-cycle, no clock edge in between
        #2;
        rst_n_a = 1'b0;
        #1;
        chk("a_async_theta", 32'(th_a), 0);
        chk("a_async_period", 32'(per_a), 0);
        chk("a_async_locked", 32'(lk_a), 0);
        chk("a_async_stall", 32'(st_a), 0);
        #1;
        rst_n_a = 1'b1;
        tick(5);
        edge_a;
        tick(1);
        chk("a_post_reset_valid", 32'(vl_a), 0);
        chk("a_post_reset_locked", 32'(lk_a), 0);

        // ---- u_b: RES=1000, P=10500 -> q=10, r=500; slices 10,11,10,11,...
        // S(2m)=21m, S(2m+1)=21m+10
        edge_b;
        tick(10499);
        edge_b;                                   // k2+1
        chk("b_period", 32'(per_b), 10500);
        tick(24);                                 // k2+25
        chk("b_lock", 32'(lk_b), 1);
        tick(10500 - 25);
        edge_b;                                   // k3+1
        tick(1);                                  // k3+2
        chk("b_edge_theta", 32'(th_b), 0);
        chk("b_edge_valid", 32'(vl_b), 1);
        tick(10);                                 // k3+12
        chk("b_s1_theta", 32'(th_b), 1);
        chk("b_s1_valid", 32'(vl_b), 1);
        tick(10);                                 // k3+22
        chk("b_s2_theta", 32'(th_b), 1);
        chk("b_s2_valid", 32'(vl_b), 0);
        tick(1);                                  // k3+23
        chk("b_s2_theta_inc", 32'(th_b), 2);
        tick(136);                                // k3+159, theta_raw=15
        chk("b_theta15", 32'(th_b), 15);
        off_b = 10'd990;
        tick(1);                                  // k3+160
        chk("b_phase_wrap", 32'(th_b), 5);
        chk("b_phase_no_strobe", 32'(vl_b), 0);
        off_b = 10'd1020;
        tick(1);                                  // k3+161
        chk("b_phase_illegal", 32'(th_b), 15);
        off_b = 10'd0;
        tick(10490 - 161);                        // k3+10490
        chk("b_theta998", 32'(th_b), 998);
        tick(1);                                  // k3+10491
        chk("b_theta999", 32'(th_b), 999);
        chk("b_valid999", 32'(vl_b), 1);
        tick(9);                                  // k4 = k3+10500
        chk("b_hold999", 32'(th_b), 999);
        chk("b_hold_valid", 32'(vl_b), 0);
        edge_b;
        chk("b_period2", 32'(per_b), 10500);

        // ---- u_c: RES=100, W=12, P=1000 -> q=10; offset 7 ----
        edge_c;
        tick(999);
        edge_c;                                   // k2+1
        chk("c_period", 32'(per_c), 1000);
        tick(12);                                 // k2+13
        chk("c_lock", 32'(lk_c), 1);
        tick(4082);                               // k2+4095
        chk("c_prestall", 32'(st_c), 0);
        chk("c_prestall_locked", 32'(lk_c), 1);
        chk("c_sat_theta_off", 32'(th_c), 6);
        tick(1);                                  // k2+4096
        chk("c_stall", 32'(st_c), 1);
        chk("c_stall_locked", 32'(lk_c), 0);
        tick(1);                                  // k2+4097
        chk("c_stall_theta", 32'(th_c), 7);
        tick(3);
        edge_c;
        chk("c_stall_clear", 32'(st_c), 0);
        chk("c_still_unlocked", 32'(lk_c), 0);
        chk("c_first_edge_period", 32'(per_c), 1000);
        tick(999);
        edge_c;
        chk("c_reperiod", 32'(per_c), 1000);
        tick(11);
        chk("c_relock_early", 32'(lk_c), 0);
        tick(1);
        chk("c_relock", 32'(lk_c), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
